mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised N-channel, W-bit registered multiplexer with a valid/ready output handshake and two selection modes: manual select (software/FSM-driven index) and round-robin auto-scan across channels that present valid data. It generalises the combinational 4:1 single-bit mux into a reusable channel-aggregation stage. It sits between multiple producer channels and a single downstream consumer.

## Interface

Parameters:
- N_CH, 4, number of input channels (2..16; need not be a power of two)
- WIDTH, 8, data width per channel
- SEL_W, $clog2(N_CH), width of select/index signals (derived; do not override)

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, synchronous, active-low
- d_in  input  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- d_valid  input  N_CH  per-channel data-valid
- d_taken  output  N_CH  one-hot, combinational; bit i high in the cycle channel i is captured
- mode  input  1  0 = manual select, 1 = round-robin scan
- select_in  input  SEL_W  channel index used in manual mode
- d_out  output  WIDTH  registered selected data
- out_sel  output  SEL_W  registered index of the channel held in d_out
- out_valid  output  1  d_out/out_sel hold a beat
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready

## Operation

- Reset (rst_n low at a clk edge): d_out = 0, out_sel = 0, out_valid = 0, round-robin pointer ptr = 0. d_taken is 0 while rst_n is low.
- Load enable: load_en = !out_valid || out_ready. When load_en is 0, d_out/out_sel/out_valid hold and d_taken = 0.
- Manual mode (mode = 0), when load_en = 1:
  - If select_in < N_CH and d_valid[select_in] = 1: capture d_in[select_in] into d_out, select_in into out_sel, set out_valid, and drive d_taken[select_in] = 1.
  - Otherwise, clear out_valid. d_out and out_sel hold and d_taken = 0.
  - ptr is not updated in manual mode.
- Round-robin mode (mode = 1), when load_en = 1:
  - Grant the first channel g with d_valid[g] = 1, searching ptr, ptr+1, …, N_CH-1, 0, …, ptr-1 (wraps modulo N_CH).
  - On a grant: capture d_in[g] and g, set out_valid, drive d_taken[g] = 1, and set ptr = (g+1) mod N_CH. The wrap is a compare against N_CH-1, not a bit truncation, so it is correct for non-power-of-two N_CH.
  - With no valid channel: clear out_valid and leave ptr unchanged.
- Mode changes take effect on the next load decision. ptr is preserved across mode changes.
- select_in and d_valid are sampled only in cycles with load_en = 1. A channel is consumed only in the cycle its d_taken bit is high. Producers hold data until they see d_taken.
- Reset asserted mid-transfer discards the held beat; it is not delivered.

## Timing

- Latency: a captured channel appears on d_out/out_valid at the clk edge after its d_taken cycle, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready stays high and a valid channel exists.
- d_taken is combinational from d_valid, mode, select_in, ptr, out_valid and out_ready. There is no combinational path from d_in to any output.
- Backpressure: while out_valid = 1 and out_ready = 0, the outputs stay stable every cycle until acceptance.
- Simultaneous accept and new capture in the same cycle are allowed. The new beat replaces the old one with no bubble.

## Test plan

- Manual sweep (N_CH=4, WIDTH=8): d_in = {8'hD3,8'hC2,8'hB1,8'hA0}, all d_valid = 1, out_ready = 1, select_in stepped 3,2,1,0 → d_out = D3,C2,B1,A0 one cycle after each select, with out_sel matching and d_taken one-hot on the selected bit.
- Reset: drive rst_n = 0 for 2 cycles after traffic → d_out = 0, out_sel = 0, out_valid = 0, and the first round-robin grant after reset is channel 0.
- Round-robin fairness: mode = 1, d_valid = 4'b1011 constant, out_ready = 1 → out_sel sequence 0,1,3,0,1,3…, and channel 2 is never granted.
- Backpressure: a beat on ch1 with out_ready = 0 for 5 cycles → d_out/out_sel/out_valid stable for 5 cycles and d_taken = 0 throughout. On out_ready = 1 the next channel loads on the same edge the old beat is accepted.
- Invalid/empty: manual select_in = 2 with d_valid[2] = 0 → out_valid drops after the beat is accepted. With N_CH=3 and select_in = 3 → no capture and d_taken = 0. Round-robin with d_valid = 0 → out_valid = 0 and ptr unchanged.
- Wrap on non-power-of-two: N_CH=3, mode = 1, all valid → out_sel cycles 0,1,2,0 with no index 3 ever produced.

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: N-channel, WIDTH-bit registered multiplexer with a valid/ready output stage.
// Two selection modes: manual (select_in picks the channel) and round-robin scan over
// channels presenting valid data.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   d_in       packed channel data, channel i at [i*WIDTH +: WIDTH]
//   d_valid    per-channel data valid
//   d_taken    one-hot, combinational: channel captured this cycle
//   mode       0 = manual select, 1 = round-robin scan
//   select_in  channel index used in manual mode
//   d_out      registered data of the held beat
//   out_sel    registered channel index of the held beat
//   out_valid  d_out/out_sel hold a beat
//   out_ready  consumer accepts the beat when out_valid && out_ready
module mux_scan #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] d_in,
  input  logic [N_CH-1:0]       d_valid,
  output logic [N_CH-1:0]       d_taken,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      select_in,
  output logic [WIDTH-1:0]      d_out,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Valid vector padded to the full index range so any select_in value indexes safely.
  localparam int unsigned     NPad   = 1 << SEL_W;
  localparam logic [SEL_W:0]  NChExt = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);

  logic [NPad-1:0]  valid_pad;
  logic             load_en;
  logic             man_ok;
  logic             rr_found;
  logic             grant;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W:0]   cand;
  logic [WIDTH-1:0] grant_data;

  logic [WIDTH-1:0] d_out_q;
  logic [SEL_W-1:0] out_sel_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;

  always_comb begin
    valid_pad = NPad'(d_valid);
    load_en   = !out_valid_q || out_ready;
    man_ok    = ({1'b0, select_in} < NChExt) && valid_pad[select_in];

    // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-two N_CH never
    // produces an index >= N_CH. One extra bit holds ptr+k before the wrap.
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = {1'b0, ptr_q} + (SEL_W + 1)'(k);
      if (cand >= NChExt) begin
        cand = cand - NChExt;
      end
      if (!rr_found && valid_pad[cand[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[SEL_W-1:0];
      end
    end

    ptr_d     = (rr_idx == LastCh) ? '0 : rr_idx + SEL_W'(1);
    grant_idx = mode ? rr_idx : select_in;
    grant     = rst_n && load_en && (mode ? rr_found : man_ok);

    grant_data = '0;
    d_taken    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = d_in[i*WIDTH +: WIDTH];
        d_taken[i] = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_out_q     <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else if (load_en) begin
      out_valid_q <= grant;
      if (grant) begin
        d_out_q   <= grant_data;
        out_sel_q <= grant_idx;
      end
      // Pointer only moves on a round-robin grant; preserved across manual mode.
      if (grant && mode) begin
        ptr_q <= ptr_d;
      end
    end
  end

  assign d_out     = d_out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_scan.sv
module tb_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [31:0] d_in4;
  logic [3:0]  dv4, dt4;
  logic        mode4, ov4, rdy4;
  logic [1:0]  sel4, osel4;
  logic [7:0]  dout4;

  logic [23:0] d_in3;
  logic [2:0]  dv3, dt3;
  logic        mode3, ov3, rdy3;
  logic [1:0]  sel3, osel3;
  logic [7:0]  dout3;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp4 [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [7:0] exp3 [3] = '{8'h11, 8'h22, 8'h33};
  int         rr_seq4 [7] = '{0, 1, 3, 0, 1, 3, 0};
  int         rr_seq3 [5] = '{0, 1, 2, 0, 1};

  mux_scan #(.N_CH(4), .WIDTH(8)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in4),
    .d_valid   (dv4),
    .d_taken   (dt4),
    .mode      (mode4),
    .select_in (sel4),
    .d_out     (dout4),
    .out_sel   (osel4),
    .out_valid (ov4),
    .out_ready (rdy4)
  );

  mux_scan #(.N_CH(3), .WIDTH(8)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in3),
    .d_valid   (dv3),
    .d_taken   (dt3),
    .mode      (mode3),
    .select_in (sel3),
    .d_out     (dout3),
    .out_sel   (osel3),
    .out_valid (ov3),
    .out_ready (rdy3)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    d_in4 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    dv4 = 4'hF; mode4 = 1'b0; sel4 = 2'd0; rdy4 = 1'b1;
    d_in3 = {8'h33, 8'h22, 8'h11};
    dv3 = 3'b111; mode3 = 1'b0; sel3 = 2'd0; rdy3 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++; if (dt4 !== 4'b0000) begin bad++; $display("FAIL reset_taken4: got %b want 0000", dt4); end
      total++; if (dt3 !== 3'b000) begin bad++; $display("FAIL reset_taken3: got %b want 000", dt3); end
      @(posedge clk); #1;
    end
    total++; if (dout4 !== 8'h00) begin bad++; $display("FAIL reset_dout4: got %h want 00", dout4); end
    total++; if (osel4 !== 2'd0) begin bad++; $display("FAIL reset_sel4: got %0d want 0", osel4); end
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_valid4: got %b want 0", ov4); end
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL reset_valid3: got %b want 0", ov3); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual_sweep();
    mode4 = 1'b0; dv4 = 4'hF; rdy4 = 1'b1;
    for (int s = 3; s >= 0; s--) begin
      @(negedge clk);
      sel4 = 2'(s);
      #1;
      total++; if (dt4 !== 4'(1 << s)) begin bad++; $display("FAIL sweep_taken ch%0d: got %b want %b", s, dt4, 4'(1 << s)); end
      @(posedge clk); #1;
      total++; if (dout4 !== exp4[s]) begin bad++; $display("FAIL sweep_dout ch%0d: got %h want %h", s, dout4, exp4[s]); end
      total++; if (osel4 !== 2'(s)) begin bad++; $display("FAIL sweep_sel: got %0d want %0d", osel4, s); end
      total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL sweep_valid ch%0d: got %b want 1", s, ov4); end
    end
  endtask

  task automatic test_rr_fairness();
    mode4 = 1'b1; dv4 = 4'b1011; rdy4 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      total++; if (dt4 !== 4'(1 << rr_seq4[i])) begin bad++; $display("FAIL rr_taken step%0d: got %b want %b", i, dt4, 4'(1 << rr_seq4[i])); end
      @(posedge clk); #1;
      total++; if (osel4 !== 2'(rr_seq4[i])) begin bad++; $display("FAIL rr_sel step%0d: got %0d want %0d", i, osel4, rr_seq4[i]); end
      total++; if (dout4 !== exp4[rr_seq4[i]]) begin bad++; $display("FAIL rr_dout step%0d: got %h want %h", i, dout4, exp4[rr_seq4[i]]); end
    end
  endtask

  // Pointer sits at 1 when reset hits; first grant afterwards must be channel 0.
  task automatic test_reset_rr();
    @(negedge clk);
    rst_n = 1'b0; dv4 = 4'hF; mode4 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (dt4 !== 4'b0000) begin bad++; $display("FAIL rst_rr_taken: got %b want 0000", dt4); end
      @(posedge clk); #1;
      total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL rst_rr_valid: got %b want 0", ov4); end
      @(negedge clk);
    end
    total++; if (dout4 !== 8'h00) begin bad++; $display("FAIL rst_rr_dout: got %h want 00", dout4); end
    total++; if (osel4 !== 2'd0) begin bad++; $display("FAIL rst_rr_sel: got %0d want 0", osel4); end
    rst_n = 1'b1;
    #1;
    total++; if (dt4 !== 4'b0001) begin bad++; $display("FAIL rst_rr_first_taken: got %b want 0001", dt4); end
    @(posedge clk); #1;
    total++; if (osel4 !== 2'd0) begin bad++; $display("FAIL rst_rr_first_sel: got %0d want 0", osel4); end
    total++; if (dout4 !== 8'hA0) begin bad++; $display("FAIL rst_rr_first_dout: got %h want a0", dout4); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    mode4 = 1'b0; sel4 = 2'd1; rdy4 = 1'b1; #1;
    total++; if (dt4 !== 4'b0010) begin bad++; $display("FAIL bp_load_taken: got %b want 0010", dt4); end
    @(posedge clk); #1;
    total++; if (dout4 !== 8'hB1) begin bad++; $display("FAIL bp_load_dout: got %h want b1", dout4); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rdy4 = 1'b0; sel4 = 2'd2; #1;
      total++; if (dt4 !== 4'b0000) begin bad++; $display("FAIL bp_hold_taken cyc%0d: got %b want 0000", c, dt4); end
      @(posedge clk); #1;
      total++; if (dout4 !== 8'hB1) begin bad++; $display("FAIL bp_hold_dout cyc%0d: got %h want b1", c, dout4); end
      total++; if (osel4 !== 2'd1) begin bad++; $display("FAIL bp_hold_sel cyc%0d: got %0d want 1", c, osel4); end
      total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc%0d: got %b want 1", c, ov4); end
    end
    @(negedge clk);
    rdy4 = 1'b1; #1;
    total++; if (dt4 !== 4'b0100) begin bad++; $display("FAIL bp_release_taken: got %b want 0100", dt4); end
    @(posedge clk); #1;
    total++; if (dout4 !== 8'hC2) begin bad++; $display("FAIL bp_release_dout: got %h want c2", dout4); end
    total++; if (osel4 !== 2'd2) begin bad++; $display("FAIL bp_release_sel: got %0d want 2", osel4); end
    total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL bp_release_valid: got %b want 1", ov4); end
  endtask

  task automatic test_invalid();
    // Manual select of an idle channel: beat held under stall, then dropped on accept.
    @(negedge clk);
    dv4 = 4'b1011; sel4 = 2'd2; rdy4 = 1'b0; #1;
    total++; if (dt4 !== 4'b0000) begin bad++; $display("FAIL inv_stall_taken: got %b want 0000", dt4); end
    @(posedge clk); #1;
    total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL inv_stall_valid: got %b want 1", ov4); end
    @(negedge clk);
    rdy4 = 1'b1; #1;
    total++; if (dt4 !== 4'b0000) begin bad++; $display("FAIL inv_accept_taken: got %b want 0000", dt4); end
    @(posedge clk); #1;
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL inv_accept_valid: got %b want 0", ov4); end
    total++; if (dout4 !== 8'hC2) begin bad++; $display("FAIL inv_hold_dout: got %h want c2", dout4); end
    total++; if (osel4 !== 2'd2) begin bad++; $display("FAIL inv_hold_sel: got %0d want 2", osel4); end

    // Out-of-range index on the 3-channel instance.
    @(negedge clk);
    mode3 = 1'b0; dv3 = 3'b111; sel3 = 2'd0; rdy3 = 1'b1; #1;
    total++; if (dt3 !== 3'b001) begin bad++; $display("FAIL oor_pre_taken: got %b want 001", dt3); end
    @(posedge clk); #1;
    total++; if (ov3 !== 1'b1) begin bad++; $display("FAIL oor_pre_valid: got %b want 1", ov3); end
    @(negedge clk);
    sel3 = 2'd3; #1;
    total++; if (dt3 !== 3'b000) begin bad++; $display("FAIL oor_taken: got %b want 000", dt3); end
    @(posedge clk); #1;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL oor_valid: got %b want 0", ov3); end
    total++; if (dout3 !== 8'h11) begin bad++; $display("FAIL oor_dout: got %h want 11", dout3); end
    total++; if (osel3 !== 2'd0) begin bad++; $display("FAIL oor_sel: got %0d want 0", osel3); end

    // Round-robin with nothing valid; pointer (1) must survive and the mode switch.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mode4 = 1'b1; dv4 = 4'b0000; #1;
      total++; if (dt4 !== 4'b0000) begin bad++; $display("FAIL rr_empty_taken: got %b want 0000", dt4); end
      @(posedge clk); #1;
      total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL rr_empty_valid: got %b want 0", ov4); end
    end
    @(negedge clk);
    dv4 = 4'hF; #1;
    total++; if (dt4 !== 4'b0010) begin bad++; $display("FAIL rr_ptr_kept_taken: got %b want 0010", dt4); end
    @(posedge clk); #1;
    total++; if (osel4 !== 2'd1) begin bad++; $display("FAIL rr_ptr_kept_sel: got %0d want 1", osel4); end
    total++; if (dout4 !== 8'hB1) begin bad++; $display("FAIL rr_ptr_kept_dout: got %h want b1", dout4); end
  endtask

  task automatic test_wrap_npot();
    mode3 = 1'b1; dv3 = 3'b111; rdy3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++; if (dt3 !== 3'(1 << rr_seq3[i])) begin bad++; $display("FAIL wrap_taken step%0d: got %b want %b", i, dt3, 3'(1 << rr_seq3[i])); end
      @(posedge clk); #1;
      total++; if (osel3 !== 2'(rr_seq3[i])) begin bad++; $display("FAIL wrap_sel step%0d: got %0d want %0d", i, osel3, rr_seq3[i]); end
      total++; if (dout3 !== exp3[rr_seq3[i]]) begin bad++; $display("FAIL wrap_dout step%0d: got %h want %h", i, dout3, exp3[rr_seq3[i]]); end
      total++; if (ov3 !== 1'b1) begin bad++; $display("FAIL wrap_valid step%0d: got %b want 1", i, ov3); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_manual_sweep();
    test_rr_fairness();
    test_reset_rr();
    test_backpressure();
    test_invalid();
    test_wrap_npot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
